// File: rtl/ez8_pkg.sv
// ez8_pkg -- shared definitions for the 8-bit core's bitwise instruction class.
//   op_e      : 3-bit instruction encodings seen by bit_rmw
//   state_e   : bit_rmw sequencer states
//   BW_OP_*   : bitwise unit function selects (AND/OR/XOR)
//   BW_B_*    : bitwise unit b-side selects (operand / constant 00 / constant FF)
//   op_needs_read, op_sets_zero : per-op decode helpers
package ez8_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_CLR  = 3'b011,
      OP_SET  = 3'b100,
      OP_BSET = 3'b101,
      OP_BCLR = 3'b110,
      OP_BTOG = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_EXEC = 3'd2,
      ST_WR   = 3'd3,
      ST_FIN  = 3'd4
   } state_e;

   localparam logic [1:0] BW_OP_AND = 2'd0;
   localparam logic [1:0] BW_OP_OR  = 2'd1;
   localparam logic [1:0] BW_OP_XOR = 2'd2;

   localparam logic [1:0] BW_B_OPND = 2'd0;
   localparam logic [1:0] BW_B_ZERO = 2'd1;
   localparam logic [1:0] BW_B_ONES = 2'd2;

   // CLR and SET produce a constant, so they skip the memory read.
   function automatic logic op_needs_read(input logic [2:0] op);
      return !((op == OP_CLR) || (op == OP_SET));
   endfunction

   // Only the byte-wide ops update the Z flag; single-bit ops leave it alone.
   function automatic logic op_sets_zero(input logic [2:0] op);
      return (op <= OP_SET);
   endfunction

endpackage

// File: rtl/bitwise.sv
// bitwise -- combinational byte logic unit.
//   a      in  8  a-side operand
//   b      in  8  b-side operand (used when b_sel = BW_B_OPND)
//   op_sel in  2  BW_OP_AND / BW_OP_OR / BW_OP_XOR
//   b_sel  in  2  BW_B_OPND / BW_B_ZERO / BW_B_ONES
//   y      out 8  result
module bitwise
   import ez8_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [1:0] op_sel,
   input  logic [1:0] b_sel,
   output logic [7:0] y
);

   logic [7:0] b_eff;

   always_comb begin
      b_eff = b;
      case (b_sel)
         BW_B_ZERO: b_eff = 8'h00;
         BW_B_ONES: b_eff = 8'hFF;
         default:   b_eff = b;
      endcase
   end

   always_comb begin
      y = a & b_eff;
      case (op_sel)
         BW_OP_OR:  y = a | b_eff;
         BW_OP_XOR: y = a ^ b_eff;
         default:   y = a & b_eff;
      endcase
   end

endmodule

// File: rtl/bit_rmw.sv
// bit_rmw -- read-modify-write sequencer for byte AND/OR/XOR, CLR/SET and
// single-bit BSET/BCLR/BTOG on a data-memory location.
//   clk, reset_n         clock, synchronous active-low reset
//   start/ready          request accepted when start & ready in the same cycle
//   op, addr, bitnum,
//   accum, dest          instruction fields, latched on accept
//   mem_addr/mem_rd      read request, held until mem_rvalid is sampled high
//   mem_rdata/mem_rvalid read data and completion
//   mem_wr/mem_wdata     write request, held until mem_wack is sampled high
//   mem_wack             write completion
//   acc_we/acc_wdata     one-cycle accumulator write
//   zero/zero_we         one-cycle Z-flag update
//   done                 one-cycle completion pulse
// Handshakes: a request output stays high until its completion input is
// sampled high on a rising edge; it drops the following cycle. Completion
// inputs arriving while the matching request is low are ignored.
module bit_rmw
   import ez8_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        bitnum,
   input  logic [7:0]        accum,
   input  logic              dest,
   output logic              ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_rvalid,
   output logic              mem_wr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_wack,
   output logic              acc_we,
   output logic [7:0]        acc_wdata,
   output logic              zero,
   output logic              zero_we,
   output logic              done
);

   state_e            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        bitnum_q, bitnum_d;
   logic [7:0]        accum_q, accum_d;
   logic              dest_q, dest_d;
   logic [7:0]        result_q, result_d;
   logic              zero_q, zero_d;

   logic              accept;
   logic              load_result;
   logic [2:0]        cur_op;
   logic [7:0]        bit_mask;
   logic [7:0]        bw_a, bw_b, bw_y;
   logic [1:0]        bw_op_sel, bw_b_sel;

   assign accept = (state_q == ST_IDLE) && start;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = op_needs_read(op) ? ST_RD : ST_EXEC;
         ST_RD:   if (mem_rvalid) state_d = ST_EXEC;
         ST_EXEC: state_d = dest_q ? ST_WR : ST_FIN;
         ST_WR:   if (mem_wack) state_d = ST_FIN;
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs (decoded from state) ----------------
   always_comb begin
      ready   = (state_q == ST_IDLE);
      mem_rd  = (state_q == ST_RD);
      mem_wr  = (state_q == ST_WR);
      acc_we  = (state_q == ST_EXEC) && !dest_q;
      zero_we = (state_q == ST_FIN) && op_sets_zero(op_q);
      done    = (state_q == ST_FIN);
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = result_q;
   assign acc_wdata = result_q;
   assign zero      = zero_q;

   // ---------------- Datapath ----------------
   // The result register must already hold the answer during EXEC (acc_we
   // fires there), so it is loaded on the edge that enters EXEC. That edge is
   // either the accept edge (CLR/SET, using the live op) or the RD edge that
   // samples mem_rvalid (using mem_rdata directly).
   assign load_result = (state_d == ST_EXEC) && (state_q != ST_EXEC);
   assign cur_op      = (state_q == ST_IDLE) ? op : op_q;
   assign bit_mask    = 8'd1 << bitnum_q;

   // Bit ops put the mask on the a-side and the memory byte on the b-side.
   always_comb begin
      bw_a      = mem_rdata;
      bw_b      = accum_q;
      bw_op_sel = BW_OP_AND;
      bw_b_sel  = BW_B_OPND;
      case (cur_op)
         OP_AND:  bw_op_sel = BW_OP_AND;
         OP_OR:   bw_op_sel = BW_OP_OR;
         OP_XOR:  bw_op_sel = BW_OP_XOR;
         OP_CLR:  begin bw_op_sel = BW_OP_AND; bw_b_sel = BW_B_ZERO; end
         OP_SET:  begin bw_op_sel = BW_OP_OR;  bw_b_sel = BW_B_ONES; end
         OP_BSET: begin bw_a = bit_mask;  bw_b = mem_rdata; bw_op_sel = BW_OP_OR;  end
         OP_BCLR: begin bw_a = ~bit_mask; bw_b = mem_rdata; bw_op_sel = BW_OP_AND; end
         OP_BTOG: begin bw_a = bit_mask;  bw_b = mem_rdata; bw_op_sel = BW_OP_XOR; end
         default: bw_op_sel = BW_OP_AND;
      endcase
   end

   bitwise u_bitwise (
      .a      (bw_a),
      .b      (bw_b),
      .op_sel (bw_op_sel),
      .b_sel  (bw_b_sel),
      .y      (bw_y)
   );

   always_comb begin
      op_d     = op_q;
      addr_d   = addr_q;
      bitnum_d = bitnum_q;
      accum_d  = accum_q;
      dest_d   = dest_q;
      result_d = result_q;
      zero_d   = zero_q;
      if (accept) begin
         op_d     = op;
         addr_d   = addr;
         bitnum_d = bitnum;
         accum_d  = accum;
         dest_d   = dest;
      end
      if (load_result) begin
         result_d = bw_y;
         zero_d   = (bw_y == 8'h00);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         op_q     <= 3'd0;
         addr_q   <= '0;
         bitnum_q <= 3'd0;
         accum_q  <= 8'h00;
         dest_q   <= 1'b0;
         result_q <= 8'h00;
         zero_q   <= 1'b0;
      end else begin
         op_q     <= op_d;
         addr_q   <= addr_d;
         bitnum_q <= bitnum_d;
         accum_q  <= accum_d;
         dest_q   <= dest_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

endmodule
